// File: rtl/mem_read_d_agen_if.sv
// Handshake and job-control bundle between the tile scheduler, the D-operand
// address generator and the D-buffer SRAM read port.
interface mem_read_d_agen_if #(
    parameter int N1           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = 12
);
    logic                    start;
    logic [MATRIXSIZE_W-1:0] M3;
    logic [MATRIXSIZE_W-1:0] M1dN1;
    logic [ADDR_W-1:0]       base_addr;
    logic                    valid_D;
    logic                    rd_ready;
    logic                    rd_valid;
    logic [ADDR_W-1:0]       rd_addr_D;
    logic [N1-1:0]           activate_D;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output start, M3, M1dN1, base_addr, valid_D, rd_ready,
        input  rd_valid, rd_addr_D, activate_D, busy, done, err
    );

    modport slave (
        input  start, M3, M1dN1, base_addr, valid_D, rd_ready,
        output rd_valid, rd_addr_D, activate_D, busy, done, err
    );
endinterface

// File: rtl/mem_read_d_agen.sv
// Read-address / row-activate generator for systolic operand D with job control,
// valid/ready output register and reversed (possibly partial) column groups.
// Optional macro MEM_READ_D_AGEN_CFGCHK_EN: reject zero-sized jobs with an err pulse.
module mem_read_d_agen #(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_read_d_agen_if.slave bus
);
    localparam int MW   = MATRIXSIZE_W;
    localparam int SR_W = (N1 > 1) ? $clog2(N1) : 1;
`ifdef MEM_READ_D_AGEN_CFGCHK_EN
    localparam bit CFGCHK = 1'b1;
`else
    localparam bit CFGCHK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [MW-1:0]     m3_reg, m1dn1_reg;
    logic [MW-1:0]     mini_col_reg, mini_offset_reg, phase_reg;
    logic [ADDR_W-1:0] base_reg, offset_reg, rd_addr_reg;
    logic [SR_W-1:0]   sys_row_reg;
    logic [N1-1:0]     activate_reg, row_onehot;
    logic              rd_valid_reg, last_issued_reg, empty_reg, err_reg;
    logic              cfg_zero, cfg_err, start_job, adv, accept;
    logic [MW-1:0]     rem, gw;
    logic              last_col, last_grp, last_row, last_phase, is_final;
    logic [ADDR_W-1:0] addr_cur;

    assign cfg_zero = (bus.M3 == '0) || (bus.M1dN1 == '0);
    assign accept   = rd_valid_reg & bus.rd_ready;
    assign adv      = (state_reg == S_RUN) & bus.valid_D & (~rd_valid_reg | bus.rd_ready)
                    & ~last_issued_reg & ~empty_reg;

    // Width of the current column group; only the final group of a row can be short.
    assign rem        = m3_reg - mini_offset_reg;
    assign gw         = (rem > MW'(N2)) ? MW'(N2) : rem;
    assign last_col   = (mini_col_reg == gw - MW'(1));
    assign last_grp   = ({1'b0, mini_offset_reg} + (MW+1)'(N2)) >= {1'b0, m3_reg};
    assign last_row   = (sys_row_reg == SR_W'(N1 - 1));
    assign last_phase = (phase_reg == m1dn1_reg - MW'(1));
    assign is_final   = last_col & last_grp & last_row & last_phase;
    assign addr_cur   = base_reg + offset_reg + ADDR_W'(mini_offset_reg)
                      + ADDR_W'(gw - MW'(1) - mini_col_reg);

    generate
        for (genvar gi = 0; gi < N1; gi++) begin : g_row_sel
            assign row_onehot[gi] = (sys_row_reg == SR_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        start_job  = 1'b0;
        cfg_err    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    if (CFGCHK && cfg_zero) begin
                        cfg_err = 1'b1;
                    end else begin
                        start_job  = 1'b1;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (empty_reg || (last_issued_reg && accept))
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= cfg_err;
        end
    end

    // Traversal counters: mini_col innermost, then group, then systolic row, then phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m3_reg          <= '0;
            m1dn1_reg       <= '0;
            base_reg        <= '0;
            mini_col_reg    <= '0;
            mini_offset_reg <= '0;
            sys_row_reg     <= '0;
            phase_reg       <= '0;
            offset_reg      <= '0;
            last_issued_reg <= 1'b0;
            empty_reg       <= 1'b0;
        end else if (start_job) begin
            m3_reg          <= bus.M3;
            m1dn1_reg       <= bus.M1dN1;
            base_reg        <= bus.base_addr;
            mini_col_reg    <= '0;
            mini_offset_reg <= '0;
            sys_row_reg     <= '0;
            phase_reg       <= '0;
            offset_reg      <= '0;
            last_issued_reg <= 1'b0;
            empty_reg       <= cfg_zero;
        end else if (adv) begin
            last_issued_reg <= is_final;
            if (!last_col) begin
                mini_col_reg <= mini_col_reg + MW'(1);
            end else begin
                mini_col_reg <= '0;
                if (!last_grp) begin
                    mini_offset_reg <= mini_offset_reg + MW'(N2);
                end else begin
                    mini_offset_reg <= '0;
                    if (!last_row) begin
                        sys_row_reg <= sys_row_reg + SR_W'(1);
                    end else begin
                        sys_row_reg <= '0;
                        phase_reg   <= phase_reg + MW'(1);
                        offset_reg  <= offset_reg + ADDR_W'(m3_reg);
                    end
                end
            end
        end
    end

    // Single output register: load on adv, hold while stalled, clear once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_addr_reg  <= '0;
            activate_reg <= '0;
        end else if (adv) begin
            rd_valid_reg <= 1'b1;
            rd_addr_reg  <= addr_cur;
            activate_reg <= row_onehot;
        end else if (accept) begin
            rd_valid_reg <= 1'b0;
            activate_reg <= '0;
        end
    end

    assign bus.rd_valid   = rd_valid_reg;
    assign bus.rd_addr_D  = rd_addr_reg;
    assign bus.activate_D = activate_reg;
    assign bus.busy       = (state_reg == S_RUN);
    assign bus.done       = (state_reg == S_DONE);
    assign bus.err        = err_reg;
endmodule
